// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two write ports, registered reads and a busy scoreboard.
// Build option: define RF_BYPASS_EN to forward same-cycle writes to reads.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NR       = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic [NR*ADDR_W-1:0]   rd_addr,
  output logic [NR*DATA_W-1:0]   rd_data,
  output logic [NR-1:0]          rd_busy,
  input  logic                   we0,
  input  logic [ADDR_W-1:0]      wa0,
  input  logic [DATA_W-1:0]      wd0,
  input  logic                   we1,
  input  logic [ADDR_W-1:0]      wa1,
  input  logic [DATA_W-1:0]      wd1,
  input  logic                   busy_set,
  input  logic [ADDR_W-1:0]      busy_addr
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_nxt;
  logic              w0_ok;
  logic              w1_ok;
  logic              set_ok;

  // Writes and issues to a hardwired zero entry are dropped.
  assign w0_ok  = we0 && !(ZERO_REG && (wa0 == '0));
  assign w1_ok  = we1 && !(ZERO_REG && (wa1 == '0));
  assign set_ok = busy_set && !(ZERO_REG && (busy_addr == '0));

  // Writeback clears, issue sets; a new producer overrides a completing one.
  always_comb begin
    busy_nxt = busy_q;
    if (w0_ok)  busy_nxt[wa0] = 1'b0;
    if (w1_ok)  busy_nxt[wa1] = 1'b0;
    if (set_ok) busy_nxt[busy_addr] = 1'b1;
  end

  // Port 1 is written last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[ADDR_W'(i)] <= '0;
      busy_q <= '0;
    end else begin
      if (w0_ok) mem[wa0] <= wd0;
      if (w1_ok) mem[wa1] <= wd1;
      busy_q <= busy_nxt;
    end
  end

  for (genvar k = 0; k < NR; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;
    logic [DATA_W-1:0] d_q;
    logic              b_q;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rv = mem[ra];
`ifdef RF_BYPASS_EN
      if (w1_ok && (wa1 == ra))      rv = wd1;
      else if (w0_ok && (wa0 == ra)) rv = wd0;
`endif
      if (ZERO_REG && (ra == '0)) rv = '0;
    end

    // Outputs hold while rd_en is low (pipeline stall).
    always_ff @(posedge clk) begin
      if (rst) begin
        d_q <= '0;
        b_q <= 1'b0;
      end else if (rd_en) begin
        d_q <= rv;
        b_q <= busy_nxt[ra];
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = d_q;
    assign rd_busy[k]                  = b_q;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (NR=2): directed scenarios plus a randomised model comparison.
module tb_regfile_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NRP = 2;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              rd_en;
  logic [NRP*AW-1:0] rd_addr;
  logic [NRP*DW-1:0] rd_data;
  logic [NRP-1:0]    rd_busy;
  logic              we0, we1, busy_set;
  logic [AW-1:0]     wa0, wa1, busy_addr;
  logic [DW-1:0]     wd0, wd1;

  typedef struct {
    logic [NRP*DW-1:0] d;
    logic [NRP-1:0]    b;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NR(NRP), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1),
    .wd1(wd1), .busy_set(busy_set), .busy_addr(busy_addr)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 1'b0; rd_en = 1'b0; rd_addr = '0;
    we0 = 1'b0; wa0 = '0; wd0 = '0;
    we1 = 1'b0; wa1 = '0; wd1 = '0;
    busy_set = 1'b0; busy_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int a0, input int a1);
    rd_en = 1'b1;
    rd_addr = {5'(a1), 5'(a0)};
  endtask

  task automatic wr0(input int a, input logic [31:0] d);
    we0 = 1'b1; wa0 = 5'(a); wd0 = d;
  endtask

  task automatic wr1(input int a, input logic [31:0] d);
    we1 = 1'b1; wa1 = 5'(a); wd1 = d;
  endtask

  task automatic push(input logic [31:0] d1, input logic [31:0] d0, input logic [1:0] b);
    exp_t e;
    e.d = {d1, d0};
    e.b = b;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    for (int s = 0; s < 3; s++) begin
      idle();
      case (s)
        0, 1: begin rst = 1'b1; wr0(5, 32'hFFFF_FFFF); busy_set = 1'b1; busy_addr = 5'd5;
                    push(0, 0, 2'b00); end
        default: begin rd(5, 31); push(0, 0, 2'b00); end
      endcase
      tick();
      e = sb.pop_front();
      checks++;
      if (rd_data !== e.d || rd_busy !== e.b) begin
        errors++;
        $display("FAIL reset step %0d: rd_data=%h rd_busy=%b expected rd_data=%h rd_busy=%b",
                 s, rd_data, rd_busy, e.d, e.b);
      end
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    for (int s = 0; s < 5; s++) begin
      idle();
      case (s)
        0: begin wr0(5, 32'hDEADBEEF); push(0, 0, 2'b00); end
        1: begin rd(5, 5); push(32'hDEADBEEF, 32'hDEADBEEF, 2'b00); end
        2: begin wr0(0, 32'h1234); push(32'hDEADBEEF, 32'hDEADBEEF, 2'b00); end
        3: begin rd(0, 5); push(32'hDEADBEEF, 0, 2'b00); end
        default: begin wr0(0, 32'hFFFF); rd(0, 0); push(0, 0, 2'b00); end
      endcase
      tick();
      e = sb.pop_front();
      checks++;
      if (rd_data !== e.d || rd_busy !== e.b) begin
        errors++;
        $display("FAIL write_read step %0d: rd_data=%h rd_busy=%b expected rd_data=%h rd_busy=%b",
                 s, rd_data, rd_busy, e.d, e.b);
      end
    end
  endtask

  task automatic test_collision();
    exp_t e;
    for (int s = 0; s < 5; s++) begin
      idle();
      case (s)
        0: begin wr0(7, 32'h77); push(0, 0, 2'b00); end
        1: begin wr0(7, 32'hAAAA0000); wr1(7, 32'h5555FFFF); rd(7, 7);
                 push(BYP ? 32'h5555FFFF : 32'h77, BYP ? 32'h5555FFFF : 32'h77, 2'b00); end
        2: begin rd(7, 7); push(32'h5555FFFF, 32'h5555FFFF, 2'b00); end
        3: begin wr0(7, 32'h1); rd(7, 3); push(0, BYP ? 32'h1 : 32'h5555FFFF, 2'b00); end
        default: begin rd(7, 3); push(0, 32'h1, 2'b00); end
      endcase
      tick();
      e = sb.pop_front();
      checks++;
      if (rd_data !== e.d || rd_busy !== e.b) begin
        errors++;
        $display("FAIL collision step %0d: rd_data=%h rd_busy=%b expected rd_data=%h rd_busy=%b",
                 s, rd_data, rd_busy, e.d, e.b);
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    for (int s = 0; s < 6; s++) begin
      idle();
      case (s)
        0: begin wr0(3, 32'h11); push(0, 32'h1, 2'b00); end
        1: begin rd(3, 3); push(32'h11, 32'h11, 2'b00); end
        2, 3, 4: begin wr0(3, 32'h22); rd_addr = {5'd7, 5'd7}; push(32'h11, 32'h11, 2'b00); end
        default: begin rd(3, 3); push(32'h22, 32'h22, 2'b00); end
      endcase
      tick();
      e = sb.pop_front();
      checks++;
      if (rd_data !== e.d || rd_busy !== e.b) begin
        errors++;
        $display("FAIL stall step %0d: rd_data=%h rd_busy=%b expected rd_data=%h rd_busy=%b",
                 s, rd_data, rd_busy, e.d, e.b);
      end
    end
  endtask

  task automatic test_scoreboard();
    exp_t e;
    for (int s = 0; s < 6; s++) begin
      idle();
      case (s)
        0: begin busy_set = 1'b1; busy_addr = 5'd9; push(32'h22, 32'h22, 2'b00); end
        1: begin rd(9, 9); push(0, 0, 2'b11); end
        2: begin wr0(9, 32'h99); busy_set = 1'b1; busy_addr = 5'd9; rd(9, 9);
                 push(BYP ? 32'h99 : 0, BYP ? 32'h99 : 0, 2'b11); end
        3: begin wr1(9, 32'h9A); rd(9, 0); push(0, BYP ? 32'h9A : 32'h99, 2'b00); end
        4: begin busy_set = 1'b1; busy_addr = 5'd12; rd(9, 12); push(0, 32'h9A, 2'b10); end
        default: begin busy_set = 1'b1; busy_addr = 5'd0; rd(0, 0); push(0, 0, 2'b00); end
      endcase
      tick();
      e = sb.pop_front();
      checks++;
      if (rd_data !== e.d || rd_busy !== e.b) begin
        errors++;
        $display("FAIL scoreboard step %0d: rd_data=%h rd_busy=%b expected rd_data=%h rd_busy=%b",
                 s, rd_data, rd_busy, e.d, e.b);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    for (int s = 0; s < 5; s++) begin
      idle();
      case (s)
        0: begin wr0(4, 32'hFF); push(0, 0, 2'b00); end
        1: begin busy_set = 1'b1; busy_addr = 5'd4; rd(4, 4); push(32'hFF, 32'hFF, 2'b11); end
        2: begin rd_addr = {5'd0, 5'd0}; push(32'hFF, 32'hFF, 2'b11); end
        3: begin rst = 1'b1; wr0(4, 32'h55); busy_set = 1'b1; busy_addr = 5'd4;
                 push(0, 0, 2'b00); end
        default: begin rd(4, 12); push(0, 0, 2'b00); end
      endcase
      tick();
      e = sb.pop_front();
      checks++;
      if (rd_data !== e.d || rd_busy !== e.b) begin
        errors++;
        $display("FAIL mid_reset step %0d: rd_data=%h rd_busy=%b expected rd_data=%h rd_busy=%b",
                 s, rd_data, rd_busy, e.d, e.b);
      end
    end
  endtask

  // Reference model of the register file, checked cycle by cycle under random traffic.
  task automatic test_random();
    exp_t        e;
    logic [31:0] m_mem [32];
    logic [31:0] m_busy;
    logic [31:0] bn;
    logic [63:0] m_d;
    logic [1:0]  m_b;
    logic [31:0] v;
    logic [4:0]  a;
    logic        w0, w1;
    m_busy = '0; m_d = '0; m_b = '0;
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    for (int s = 0; s < 400; s++) begin
      idle();
      rst = (s == 0) || ($urandom_range(0, 39) == 0);
      rd_en = ($urandom_range(0, 3) != 0);
      rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      we0 = 1'($urandom_range(0, 1)); wa0 = 5'($urandom_range(0, 7)); wd0 = $urandom;
      we1 = 1'($urandom_range(0, 1)); wa1 = 5'($urandom_range(0, 7)); wd1 = $urandom;
      busy_set = 1'($urandom_range(0, 1)); busy_addr = 5'($urandom_range(0, 7));
      if (rst) begin
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_busy = '0; m_d = '0; m_b = '0;
      end else begin
        w0 = we0 && (wa0 != 0);
        w1 = we1 && (wa1 != 0);
        bn = m_busy;
        if (w0) bn[wa0] = 1'b0;
        if (w1) bn[wa1] = 1'b0;
        if (busy_set && busy_addr != 0) bn[busy_addr] = 1'b1;
        if (rd_en) begin
          for (int k = 0; k < 2; k++) begin
            a = rd_addr[k*5 +: 5];
            v = m_mem[a];
            if (BYP && w1 && wa1 == a) v = wd1;
            else if (BYP && w0 && wa0 == a) v = wd0;
            if (a == 0) v = '0;
            m_d[k*32 +: 32] = v;
            m_b[k] = bn[a];
          end
        end
        if (w0) m_mem[wa0] = wd0;
        if (w1) m_mem[wa1] = wd1;
        m_busy = bn;
      end
      e.d = m_d;
      e.b = m_b;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      checks++;
      if (rd_data !== e.d || rd_busy !== e.b) begin
        errors++;
        $display("FAIL random cycle %0d: rd_data=%h rd_busy=%b expected rd_data=%h rd_busy=%b",
                 s, rd_data, rd_busy, e.d, e.b);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();
    test_reset();
    test_write_read();
    test_collision();
    test_stall();
    test_scoreboard();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
